// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell iterated LSB-first over WIDTH cycles,
// with valid/ready handshakes on operands and result and a serial debug stream of difference bits.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             diff_bit,
  output logic             diff_bit_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_next;

  function automatic logic sub_diff(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic sub_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  always_comb begin
    d_bit   = sub_diff(a_reg[0], b_reg[0], borrow_reg);
    br_next = sub_borrow(a_reg[0], b_reg[0], borrow_reg);
  end

  assign in_ready       = (state == IDLE);
  assign out_valid      = (state == DONE);
  assign diff_bit_valid = (state == RUN);
  assign diff_bit       = (state == RUN) & d_bit;
  assign diff_out       = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result     <= '0;
      borrow_reg <= 1'b0;
      borrow_out <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= a_in;
            b_reg      <= b_in;
            borrow_reg <= borrow_in;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
          a_reg      <= {1'b0, a_reg[WIDTH-1:1]};
          b_reg      <= {1'b0, b_reg[WIDTH-1:1]};
          result     <= {d_bit, result[WIDTH-1:1]};
          borrow_reg <= br_next;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST) begin
            borrow_out <= br_next;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vector table plus corner sequences,
// and an exhaustive WIDTH=4 sweep against a modular-difference reference.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, bin8 = 1'b0, bo8, db8, dbv8;
  logic [7:0] a8 = '0, b8 = '0, d8;

  // WIDTH=4 instance
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b0, bin4 = 1'b0, bo4, db4, dbv4;
  logic [3:0] a4 = '0, b4 = '0, d4;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
    .borrow_in(bin8), .out_valid(ov8), .out_ready(or8), .diff_out(d8),
    .borrow_out(bo8), .diff_bit(db8), .diff_bit_valid(dbv8));

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a_in(a4), .b_in(b4),
    .borrow_in(bin4), .out_valid(ov4), .out_ready(or4), .diff_out(d4),
    .borrow_out(bo4), .diff_bit(db4), .diff_bit_valid(dbv4));

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready8();
    int n = 0;
    @(negedge clk);
    while (!ir8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w8_ready_timeout", 32'(ir8), 32'd1);
  endtask

  // Full operation on the 8-bit instance with stream, latency and result checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb);
    wait_ready8();
    a8 = a; b8 = b; bin8 = bin; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("w8_dbv_run", 32'(dbv8), 32'd1);
      chk($sformatf("w8_dbit%0d", k), 32'(db8), 32'(ed[k]));
      if (k == 7) chk("w8_ov_early", 32'(ov8), 32'd0);
      @(negedge clk);
    end
    chk("w8_ov_latency", 32'(ov8), 32'd1);
    chk("w8_dbv_done", 32'(dbv8), 32'd0);
    chk("w8_diff", 32'(d8), 32'(ed));
    chk("w8_borrow", 32'(bo8), 32'(eb));
    @(negedge clk);
    chk("w8_ready_after", 32'(ir8), 32'd1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int n = 0;
    logic [3:0] ed;
    logic       eb;
    ed = 4'(5'(a) - 5'(b) - 5'(bin));
    eb = (5'(a) < 5'(b) + 5'(bin));
    @(negedge clk);
    while (!ir4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ir4) chk("w4_ready_timeout", 32'(ir4), 32'd1);
    a4 = a; b4 = b; bin4 = bin; iv4 = 1'b1; or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("w4_ov_early", 32'(ov4), 32'd0);
    @(negedge clk);
    chk("w4_ov_latency", 32'(ov4), 32'd1);
    chk($sformatf("w4_diff_%0h_%0h_%0b", a, b, bin), 32'(d4), 32'(ed));
    chk($sformatf("w4_borrow_%0h_%0h_%0b", a, b, bin), 32'(bo4), 32'(eb));
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};

    // Asynchronous reset asserted mid-cycle
    #12 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ir8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_diff_out", 32'(d8), 32'd0);
    chk("rst_borrow_out", 32'(bo8), 32'd0);
    chk("rst_diff_bit", 32'(db8), 32'd0);
    chk("rst_diff_bit_valid", 32'(dbv8), 32'd0);
    chk("rst_w4_in_ready", 32'(ir4), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].borrow);

    // Backpressure: result held in DONE; operands offered during RUN/DONE are ignored
    wait_ready8();
    a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
    repeat (8) @(negedge clk);
    chk("bp_ov", 32'(ov8), 32'd1);
    chk("bp_diff", 32'(d8), 32'h37);
    chk("bp_borrow", 32'(bo8), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_ov", 32'(ov8), 32'd1);
      chk("bp_hold_in_ready", 32'(ir8), 32'd0);
      chk("bp_hold_diff", 32'(d8), 32'h37);
      chk("bp_hold_borrow", 32'(bo8), 32'd0);
    end
    or8 = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(ir8), 32'd1);
    chk("bp_release_ov", 32'(ov8), 32'd0);
    chk("bp_release_dbv", 32'(dbv8), 32'd0);
    iv8 = 1'b0;
    op8(8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0);

    // Reset during the 4th RUN cycle
    wait_ready8();
    a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_dbv_before", 32'(dbv8), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_in_ready", 32'(ir8), 32'd1);
    chk("mid_out_valid", 32'(ov8), 32'd0);
    chk("mid_dbv", 32'(dbv8), 32'd0);
    chk("mid_diff_bit", 32'(db8), 32'd0);
    chk("mid_diff_out", 32'(d8), 32'd0);
    chk("mid_borrow_out", 32'(bo8), 32'd0);
    #1 rst = 1'b0;
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(4'(a), 4'(b), 1'(c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
